// File: rtl/fft16_stage_sequencer_if.sv
// rtl/fft16_stage_sequencer_if.sv - frame handshake and stage-control bundle of the FFT stage sequencer
interface fft16_stage_sequencer_if #(
  parameter int CW = 2
);
  logic          i_start;
  logic          i_abort;
  logic          o_busy;
  logic          o_done;
  logic [1:0]    o_choose_twiddle;
  logic [1:0]    o_stage;
  logic          o_bf_en;
  logic [CW-1:0] o_bf_cnt;
  logic          o_swap;

  // Frame controller side: issues start/abort, observes progress.
  modport master (
    output i_start,
    output i_abort,
    input  o_busy,
    input  o_done,
    input  o_choose_twiddle,
    input  o_stage,
    input  o_bf_en,
    input  o_bf_cnt,
    input  o_swap
  );

  // Sequencer side.
  modport slave (
    input  i_start,
    input  i_abort,
    output o_busy,
    output o_done,
    output o_choose_twiddle,
    output o_stage,
    output o_bf_en,
    output o_bf_cnt,
    output o_swap
  );
endinterface

// File: rtl/fft16_stage_sequencer.sv
// rtl/fft16_stage_sequencer.sv - per-stage LOAD/RUN/WB sequencer for the 16-point radix-2 FFT
module fft16_stage_sequencer #(
  parameter int STAGES       = 4,
  parameter int STAGE_CYCLES = 4,
  parameter int ROM_LAT      = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  fft16_stage_sequencer_if.slave    bus
);

  // Butterfly index width, and a shared counter wide enough for both the
  // ROM settling wait and the butterfly run.
  localparam int CW = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;
  localparam int LW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam int NW = (CW > LW) ? CW : LW;

  localparam logic [NW-1:0] LOAD_LAST  = NW'(ROM_LAT - 1);
  localparam logic [NW-1:0] RUN_LAST   = NW'(STAGE_CYCLES - 1);
  localparam logic [1:0]    STAGE_LAST = 2'(STAGES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_WB   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [NW-1:0]   r_cnt;
  logic [NW-1:0]   w_cnt_nxt;
  logic [1:0]      r_stage;
  logic [1:0]      w_stage_nxt;

  // State, shared counter and stage index registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_stage <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stage <= w_stage_nxt;
    end
  end

  // Next-state logic; the counter restarts at 0 on every state entry and
  // abort from any active state overrides the normal flow.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stage_nxt = r_stage;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start && !bus.i_abort) begin
          w_state_nxt = S_LOAD;
          w_cnt_nxt   = '0;
          w_stage_nxt = 2'd0;
        end
      end
      S_LOAD: begin
        if (r_cnt == LOAD_LAST) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + NW'(1);
        end
      end
      S_RUN: begin
        if (r_cnt == RUN_LAST) begin
          w_state_nxt = S_WB;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + NW'(1);
        end
      end
      S_WB: begin
        w_cnt_nxt = '0;
        if (r_stage == STAGE_LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_LOAD;
          w_stage_nxt = r_stage + 2'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_stage_nxt = 2'd0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_stage_nxt = 2'd0;
      end
    endcase
    if (bus.i_abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_stage_nxt = 2'd0;
    end
  end

  // Outputs decoded purely from registered state; no input reaches an output
  // within the same cycle.
  assign bus.o_busy           = (r_state != S_IDLE);
  assign bus.o_done           = (r_state == S_DONE);
  assign bus.o_bf_en          = (r_state == S_RUN);
  assign bus.o_swap           = (r_state == S_WB);
  assign bus.o_bf_cnt         = (r_state == S_RUN) ? r_cnt[CW-1:0] : '0;
  assign bus.o_stage          = r_stage;
  assign bus.o_choose_twiddle = r_stage;

endmodule

// File: tb/tb_fft16_stage_sequencer.sv
// tb/tb_fft16_stage_sequencer.sv - directed self-checking bench for fft16_stage_sequencer
module tb_fft16_stage_sequencer;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  fft16_stage_sequencer_if #(.CW(2)) if0 ();
  fft16_stage_sequencer_if #(.CW(1)) if1 ();

  fft16_stage_sequencer dut0 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (if0.slave)
  );

  fft16_stage_sequencer #(.STAGES(2), .STAGE_CYCLES(1), .ROM_LAT(2)) dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle stimulus and captured outputs; cycle 0 is the cycle in which start is first driven.
  logic st_v [64];
  logic ab_v [64];
  logic [7:0] cap [64];

  function automatic logic [7:0] pack(input logic busy, input logic done, input logic en,
                                      input logic [1:0] cnt, input logic sw, input logic [1:0] tw);
    return {busy, done, en, cnt, sw, tw};
  endfunction

  function automatic logic [7:0] now0();
    return pack(if0.o_busy, if0.o_done, if0.o_bf_en, if0.o_bf_cnt, if0.o_swap, if0.o_choose_twiddle);
  endfunction

  task automatic clear_stim();
    for (int i = 0; i < 64; i++) begin
      st_v[i] = 1'b0;
      ab_v[i] = 1'b0;
    end
  endtask

  // Sample outputs on the falling edge, then drive that cycle's inputs; finish with an abort so the DUT is idle.
  task automatic capture(input int n, input bit sel);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!sel) begin
        cap[i] = now0();
        if0.i_start = st_v[i];
        if0.i_abort = ab_v[i];
      end else begin
        cap[i] = pack(if1.o_busy, if1.o_done, if1.o_bf_en, {1'b0, if1.o_bf_cnt}, if1.o_swap, if1.o_choose_twiddle);
        if1.i_start = st_v[i];
        if1.i_abort = ab_v[i];
      end
    end
    @(negedge clk);
    if0.i_start = 1'b0; if0.i_abort = 1'b1;
    if1.i_start = 1'b0; if1.i_abort = 1'b1;
    @(negedge clk);
    if0.i_abort = 1'b0;
    if1.i_abort = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total++;
    if (now0() !== 8'h00) begin
      bad++; $display("FAIL reset_state got=%b exp=%b", now0(), 8'h00);
    end
    rst_n = 1'b1;
    @(negedge clk); if0.i_start = 1'b1;
    @(negedge clk); if0.i_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (now0() !== pack(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0)) begin
      bad++; $display("FAIL reset_pre_run got=%b exp=%b", now0(), pack(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0));
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (now0() !== 8'h00) begin
      bad++; $display("FAIL reset_async got=%b exp=%b", now0(), 8'h00);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (now0() !== 8'h00) begin
        bad++; $display("FAIL reset_idle_after c=%0d got=%b exp=%b", i, now0(), 8'h00);
      end
    end
  endtask

  task automatic test_frame();
    logic [7:0] e;
    int t;
    clear_stim();
    st_v[0] = 1'b1;
    capture(27, 1'b0);
    for (int c = 0; c < 27; c++) begin
      t = c - 1;
      if (c >= 1 && c <= 24)
        e = pack(1'b1, 1'b0, (t % 6 >= 1 && t % 6 <= 4),
                 (t % 6 >= 1 && t % 6 <= 4) ? 2'(t % 6 - 1) : 2'd0,
                 (t % 6 == 5), 2'(t / 6));
      else if (c == 25)
        e = pack(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, cap[c][1:0]);
      else
        e = 8'h00;
      total++;
      if (cap[c] !== e) begin
        bad++; $display("FAIL frame c=%0d got=%b exp=%b", c, cap[c], e);
      end
    end
  endtask

  task automatic test_start_ignored();
    int n_done, n_en, n_sw;
    clear_stim();
    st_v[0]  = 1'b1;
    st_v[10] = 1'b1;
    capture(32, 1'b0);
    n_done = 0; n_en = 0; n_sw = 0;
    for (int c = 0; c < 32; c++) begin
      n_done += int'(cap[c][6]);
      n_en   += int'(cap[c][5]);
      n_sw   += int'(cap[c][2]);
    end
    total++;
    if (n_done != 1) begin bad++; $display("FAIL ignored_done_count got=%0d exp=%0d", n_done, 1); end
    total++;
    if (cap[25][6] !== 1'b1) begin bad++; $display("FAIL ignored_done_cycle got=%b exp=%b", cap[25][6], 1'b1); end
    total++;
    if (n_en != 16) begin bad++; $display("FAIL ignored_bf_en_count got=%0d exp=%0d", n_en, 16); end
    total++;
    if (n_sw != 4) begin bad++; $display("FAIL ignored_swap_count got=%0d exp=%0d", n_sw, 4); end
  endtask

  task automatic test_abort();
    int n_sw, n_en, n_done;
    clear_stim();
    st_v[0]  = 1'b1;
    ab_v[16] = 1'b1;
    capture(30, 1'b0);
    total++;
    if (cap[16] !== pack(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 2'd2)) begin
      bad++; $display("FAIL abort_at got=%b exp=%b", cap[16], pack(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 2'd2));
    end
    for (int c = 17; c < 30; c++) begin
      total++;
      if (cap[c] !== 8'h00) begin
        bad++; $display("FAIL abort_idle c=%0d got=%b exp=%b", c, cap[c], 8'h00);
      end
    end
    n_sw = 0;
    for (int c = 0; c < 30; c++) n_sw += int'(cap[c][2]);
    total++;
    if (n_sw != 2) begin bad++; $display("FAIL abort_swap_count got=%0d exp=%0d", n_sw, 2); end

    clear_stim();
    st_v[0] = 1'b1;
    ab_v[0] = 1'b1;
    capture(4, 1'b0);
    for (int c = 1; c < 4; c++) begin
      total++;
      if (cap[c][7] !== 1'b0) begin
        bad++; $display("FAIL abort_wins c=%0d got=%b exp=%b", c, cap[c][7], 1'b0);
      end
    end

    clear_stim();
    st_v[0] = 1'b1;
    capture(28, 1'b0);
    n_en = 0; n_sw = 0; n_done = 0;
    for (int c = 0; c < 28; c++) begin
      n_en   += int'(cap[c][5]);
      n_sw   += int'(cap[c][2]);
      n_done += int'(cap[c][6]);
    end
    total++;
    if (cap[25][6] !== 1'b1 || n_done != 1) begin
      bad++; $display("FAIL abort_refrm_done got=%b/%0d exp=1/1", cap[25][6], n_done);
    end
    total++;
    if (n_en != 16 || n_sw != 4) begin
      bad++; $display("FAIL abort_refrm_counts got=%0d/%0d exp=16/4", n_en, n_sw);
    end
  endtask

  task automatic test_back_to_back();
    int n_en;
    logic e_busy, e_done;
    clear_stim();
    for (int i = 0; i < 56; i++) st_v[i] = 1'b1;
    capture(56, 1'b0);
    n_en = 0;
    for (int c = 0; c < 56; c++) begin
      e_busy = !(c == 0 || c == 26 || c == 52);
      e_done = (c == 25 || c == 51);
      n_en += int'(cap[c][5]);
      total++;
      if (cap[c][7:6] !== {e_busy, e_done}) begin
        bad++; $display("FAIL b2b c=%0d got=%b exp=%b", c, cap[c][7:6], {e_busy, e_done});
      end
    end
    total++;
    if (n_en != 34) begin bad++; $display("FAIL b2b_bf_en_count got=%0d exp=%0d", n_en, 34); end
  endtask

  task automatic test_params();
    logic [7:0] e;
    int t;
    clear_stim();
    st_v[0] = 1'b1;
    capture(12, 1'b1);
    for (int c = 0; c < 12; c++) begin
      t = c - 1;
      if (c >= 1 && c <= 8)
        e = pack(1'b1, 1'b0, (t % 4 == 2), 2'd0, (t % 4 == 3), 2'(t / 4));
      else if (c == 9)
        e = pack(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, cap[c][1:0]);
      else
        e = 8'h00;
      total++;
      if (cap[c] !== e) begin
        bad++; $display("FAIL params c=%0d got=%b exp=%b", c, cap[c], e);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    if0.i_start = 1'b0; if0.i_abort = 1'b0;
    if1.i_start = 1'b0; if1.i_abort = 1'b0;
    clear_stim();
    test_reset();
    test_frame();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    test_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
